sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Message-schedule stage of the SHA-256 datapath. It accepts one 512-bit padded message block and streams the 64 schedule words W[0]..W[63] to the compression rounds over a valid/ready handshake, one word per cycle when not stalled. It is the consumer side of the block buffer and the producer feeding the round logic. It uses the existing rotate_right module for every rotation.

## Interface
- ROUNDS, 64: schedule words emitted per block; fixed for SHA-256 and checked at elaboration.
- WORD_W, 32: schedule word width; fixed for SHA-256 and checked at elaboration.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- blk_valid  in  1  a block is offered on blk_data.
- blk_ready  out  1  block can be accepted.
- blk_data  in  512  block, big-endian: W[0] = [511:480], W[15] = [31:0].
- w_valid  out  1  w_data holds a valid schedule word.
- w_ready  in  1  round logic accepts the word.
- w_data  out  32  W[t].
- w_idx  out  6  t, the index of the current word.
- w_last  out  1  high with w_valid when t = 63.
- busy  out  1  block in progress (state RUN).

## Operation
- Two states.
  - IDLE: blk_ready = 1, w_valid = 0.
  - RUN: blk_ready = 0, w_valid = 1.
- IDLE -> RUN on blk_valid && blk_ready.
  - Load the 16-entry window: win[i] = W[i] from blk_data.
  - Set t = 0.
- In RUN, w_data = win[0] and w_idx = t.
- Word handshake (w_valid && w_ready):
  - shift the window down: win[i] <= win[i+1];
  - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32;
  - t <= t + 1.
- Sigma functions:
  - s0(x) = rotr7(x) ^ rotr18(x) ^ shr3(x);
  - s1(x) = rotr17(x) ^ rotr19(x) ^ shr10(x);
  - shifts are logical, zero-filled.
- The window computes new words through t = 63. Words computed after t = 47 are never emitted; that is harmless and no gating is required.
- Handshake on w_last (t = 63) -> IDLE. t wraps to 0 and the window contents are don't-care.
- w_ready low holds w_data, w_idx, w_last and the window unchanged; the stall can last any number of cycles.
- No block overlap: blk_valid during RUN is ignored and blk_data is not sampled.
- blk_data is sampled only on the accept edge and may change afterwards.

## Timing
- Reset (rst_n low, async): state IDLE, t = 0, window cleared.
  - Outputs during reset: blk_ready = 1, w_valid = 0, w_last = 0, busy = 0, w_data = 0, w_idx = 0.
- Reset mid-block aborts the block immediately. No further words are emitted and the next block restarts at t = 0.
- Block accepted at edge N: w_valid = 1 with W[0] in the cycle after N.
- With w_ready held high, W[t] is presented in cycle N+1+t, and the last handshake is at edge N+64.
- blk_ready returns high in the cycle after the w_last handshake, so back-to-back blocks need 65 cycles each.
- All outputs are registered or decoded directly from state/t/window; there is no combinational path from w_ready or blk_valid to any output.
- Addition and XOR form one combinational stage between win registers. The target is the miner clock with no pipelining inside the adder tree.

## Structure
- sha256_pkg holds:
  - WORD_W = 32, SCHED_ROUNDS = 64, WIN_DEPTH = 16;
  - the state enum (IDLE, RUN);
  - rotation constants 7/18/3 and 17/19/10.
- Sub-module sha256_small_sigma, parameterised by (R1, R2, S):
  - two rotate_right instances plus a logical shift, XORed;
  - instantiated twice, once for s0 and once for s1.
- The top holds the FSM, counter, window and the adder.

## Test plan
- "abc" block (0x61626380, 14 zero words, 0x00000018), w_ready = 1:
  - W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000F0000;
  - all 64 words match the golden model;
  - w_last only at idx 63.
- Same block, w_ready toggled pseudo-randomly: the word sequence is identical, and w_data/w_idx are stable while stalled.
- blk_valid held high with two distinct blocks queued:
  - the second is accepted exactly one cycle after the first block's w_last handshake;
  - blk_data changes during RUN are ignored.
- All-ones block (0xFFFFFFFF x16): W[16] = s1(0xFFFFFFFF) + 0xFFFFFFFF + s0(0xFFFFFFFF) + 0xFFFFFFFF, mod 2^32, matching the model. This exercises carry wrap.
- rst_n pulsed low at t = 30:
  - w_valid drops asynchronously and blk_ready = 1;
  - a new block then restarts at idx 0 with correct words.
- After reset with no block offered: w_valid stays 0 and busy stays 0 for 100 cycles.

Source files
------------

// File: rtl/sha256_msg_schedule_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared constants and types for the SHA-256 message-schedule stage.
//   WORD_W        schedule word width
//   SCHED_ROUNDS  schedule words emitted per block
//   WIN_DEPTH     depth of the sliding 16-word window
//   BLK_W         width of one padded message block
//   IDX_W         width of the word index t
//   state_e       schedule FSM states
//   S0_* / S1_*   rotate/shift amounts of the two small sigma functions
// -----------------------------------------------------------------------------
package sha256_pkg;

   localparam int WORD_W       = 32;
   localparam int SCHED_ROUNDS = 64;
   localparam int WIN_DEPTH    = 16;
   localparam int BLK_W        = WORD_W * WIN_DEPTH;
   localparam int IDX_W        = 6;

   // s0(x) = rotr7 ^ rotr18 ^ shr3
   localparam int S0_ROT1 = 7;
   localparam int S0_ROT2 = 18;
   localparam int S0_SHR  = 3;

   // s1(x) = rotr17 ^ rotr19 ^ shr10
   localparam int S1_ROT1 = 17;
   localparam int S1_ROT2 = 19;
   localparam int S1_SHR  = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : sha256_pkg

// File: rtl/sha256_msg_schedule_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule_if
// Bundles the block-input handshake and the schedule-word output stream.
//   blk_valid/blk_ready/blk_data  512-bit block in, big-endian words
//   w_valid/w_ready               schedule word handshake
//   w_data/w_idx/w_last           word W[t], index t, last-word flag
//   busy                          a block is in progress
// Modports: slave = the schedule stage, master = block source + round logic.
// -----------------------------------------------------------------------------
interface sha256_msg_schedule_if;
   import sha256_pkg::*;

   logic               blk_valid;
   logic               blk_ready;
   logic [BLK_W-1:0]   blk_data;
   logic               w_valid;
   logic               w_ready;
   logic [WORD_W-1:0]  w_data;
   logic [IDX_W-1:0]   w_idx;
   logic               w_last;
   logic               busy;

   modport slave (
      input  blk_valid, blk_data, w_ready,
      output blk_ready, w_valid, w_data, w_idx, w_last, busy
   );

   modport master (
      output blk_valid, blk_data, w_ready,
      input  blk_ready, w_valid, w_data, w_idx, w_last, busy
   );

endinterface : sha256_msg_schedule_if

// File: rtl/rotate_right.sv
// -----------------------------------------------------------------------------
// rotate_right
// Constant-amount right rotation, pure wiring.
//   data_i  input word
//   data_o  data_i rotated right by AMOUNT bits
// -----------------------------------------------------------------------------
module rotate_right #(
   parameter int WIDTH  = 32,
   parameter int AMOUNT = 1
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign data_o[gi] = data_i[(gi + AMOUNT) % WIDTH];
   end

endmodule : rotate_right

// File: rtl/sha256_msg_schedule_small_sigma.sv
// -----------------------------------------------------------------------------
// sha256_small_sigma
// SHA-256 small sigma: rotr(R1) ^ rotr(R2) ^ shr(S), logical zero-fill shift.
//   x_i  input word
//   y_o  sigma(x_i)
// -----------------------------------------------------------------------------
module sha256_small_sigma
   import sha256_pkg::*;
#(
   parameter int R1 = 7,
   parameter int R2 = 18,
   parameter int S  = 3
) (
   input  logic [WORD_W-1:0] x_i,
   output logic [WORD_W-1:0] y_o
);

   logic [WORD_W-1:0] rot1;
   logic [WORD_W-1:0] rot2;

   rotate_right #(.WIDTH(WORD_W), .AMOUNT(R1)) u_rot1 (.data_i(x_i), .data_o(rot1));
   rotate_right #(.WIDTH(WORD_W), .AMOUNT(R2)) u_rot2 (.data_i(x_i), .data_o(rot2));

   assign y_o = rot1 ^ rot2 ^ (x_i >> S);

endmodule : sha256_small_sigma

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
// Accepts one padded 512-bit block and streams W[0]..W[63] one word per
// handshake. A 16-word window slides down on every accepted word; the new
// tail word is computed from the window in a single combinational stage.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sched_if   block-in / word-out handshakes (slave modport)
// -----------------------------------------------------------------------------
module sha256_msg_schedule #(
   parameter int ROUNDS = 64,
   parameter int WORD_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sha256_msg_schedule_if.slave    sched_if
);
   import sha256_pkg::*;

   if (ROUNDS != sha256_pkg::SCHED_ROUNDS) begin : g_bad_rounds
      $error("sha256_msg_schedule: ROUNDS must be 64");
   end
   if (WORD_W != sha256_pkg::WORD_W) begin : g_bad_width
      $error("sha256_msg_schedule: WORD_W must be 32");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   state_e              state_q;
   logic [IDX_W-1:0]    t_q;
   logic [WORD_W-1:0]   win_q [WIN_DEPTH];

   logic [WORD_W-1:0]   s0_w;
   logic [WORD_W-1:0]   s1_w;
   logic [WORD_W-1:0]   tail_d;
   logic                word_hs;

   sha256_small_sigma #(.R1(S0_ROT1), .R2(S0_ROT2), .S(S0_SHR)) u_sigma0 (
      .x_i (win_q[1]),
      .y_o (s0_w)
   );

   sha256_small_sigma #(.R1(S1_ROT1), .R2(S1_ROT2), .S(S1_SHR)) u_sigma1 (
      .x_i (win_q[14]),
      .y_o (s1_w)
   );

   // W[t+16] relative to the window head W[t]; it lands in the tail slot
   // while the rest of the window shifts down.
   assign tail_d  = s1_w + win_q[9] + s0_w + win_q[0];
   assign word_hs = (state_q == RUN) && sched_if.w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         for (int i = 0; i < WIN_DEPTH; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (sched_if.blk_valid) begin
                  for (int i = 0; i < WIN_DEPTH; i++) begin
                     win_q[i] <= sched_if.blk_data[BLK_W-1-WORD_W*i -: WORD_W];
                  end
                  t_q     <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (word_hs) begin
                  for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                     win_q[i] <= win_q[i+1];
                  end
                  win_q[WIN_DEPTH-1] <= tail_d;
                  // t wraps to 0 on the last word
                  t_q <= t_q + IDX_W'(1);
                  if (t_q == LAST_IDX) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sched_if.blk_ready = (state_q == IDLE);
   assign sched_if.w_valid   = (state_q == RUN);
   assign sched_if.busy      = (state_q == RUN);
   assign sched_if.w_data    = win_q[0];
   assign sched_if.w_idx     = t_q;
   assign sched_if.w_last    = (state_q == RUN) && (t_q == LAST_IDX);

endmodule : sha256_msg_schedule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Drives blocks into the schedule stage and compares the word stream against
// the textbook expanded-array form of the SHA-256 message schedule.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

   logic clk;
   logic rst_n;

   sha256_msg_schedule_if bus();

   sha256_msg_schedule #(.ROUNDS(64), .WORD_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sched_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   logic [31:0] exp_w [64];
   logic [31:0] got_d [64];
   logic [5:0]  got_i [64];
   logic        got_l [64];
   int          got_n;
   int          got_unstable;
   int          got_cycles;
   bit          got_to;

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_model(input logic [511:0] b);
      for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         exp_w[i] = sig1(exp_w[i-2]) + exp_w[i-7] + sig0(exp_w[i-15]) + exp_w[i-16];
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   // Offers a block; returns at #1 after the accept edge.
   task automatic offer(input logic [511:0] d, input bit keep_valid, output bit to);
      to = 1'b0;
      bus.blk_data  = d;
      bus.blk_valid = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (bus.blk_ready === 1'b1) begin
            @(posedge clk); #1;
            if (!keep_valid) begin
               bus.blk_valid = 1'b0;
               bus.blk_data  = rand_block();
            end
            return;
         end
         @(posedge clk); #1;
      end
      to = 1'b1;
      bus.blk_valid = 1'b0;
   endtask

   // Collects handshaken words starting from the current cycle. Stops after
   // the w_last handshake (returns at #1 after that edge) or when w_idx
   // reaches stop_idx (returns in that cycle, word not taken).
   task automatic collect(input bit rnd, input int stop_idx);
      bit          r;
      bit          stalled_prev;
      bit          done;
      logic [31:0] prev_d;
      logic [5:0]  prev_i;
      got_n = 0; got_unstable = 0; got_cycles = 0; got_to = 1'b0;
      stalled_prev = 1'b0;
      forever begin
         if (got_cycles > 3000 || got_n >= 64) begin
            got_to = (got_cycles > 3000);
            break;
         end
         if (stalled_prev && (bus.w_data !== prev_d || bus.w_idx !== prev_i))
            got_unstable++;
         if (bus.w_valid === 1'b1 && int'(bus.w_idx) == stop_idx) begin
            bus.w_ready = 1'b0;
            break;
         end
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.w_ready = r;
         done = 1'b0;
         if (bus.w_valid === 1'b1 && r) begin
            got_d[got_n] = bus.w_data;
            got_i[got_n] = bus.w_idx;
            got_l[got_n] = bus.w_last;
            got_n++;
            done = (bus.w_last === 1'b1);
         end
         stalled_prev = (bus.w_valid === 1'b1) && !r;
         prev_d = bus.w_data;
         prev_i = bus.w_idx;
         @(posedge clk); #1;
         got_cycles++;
         if (done) break;
      end
      bus.w_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.w_last !== 1'b0 ||
          bus.busy !== 1'b0 || bus.w_data !== 32'd0 || bus.w_idx !== 6'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b data=%h idx=%0d, need 1 0 0 0 0 0",
                  bus.blk_ready, bus.w_valid, bus.w_last, bus.busy, bus.w_data, bus.w_idx);
      end
   endtask

   task automatic test_abc();
      logic [511:0] b;
      bit to;
      int bad;
      b = '0;
      b[511:480] = 32'h61626380;
      b[31:0]    = 32'h00000018;
      build_model(b);
      offer(b, 1'b0, to);
      checks++;
      if (to || bus.w_valid !== 1'b1 || bus.w_idx !== 6'd0 || bus.w_data !== 32'h61626380) begin
         errors++;
         $display("FAIL abc_first_word: got to=%0d vld=%b idx=%0d data=%h, need vld=1 idx=0 data=61626380",
                  to, bus.w_valid, bus.w_idx, bus.w_data);
      end
      collect(1'b0, -1);
      checks++;
      if (got_to || got_n != 64 || got_cycles != 64) begin
         errors++;
         $display("FAIL abc_count: got words=%0d cycles=%0d to=%0d, need 64 64 0", got_n, got_cycles, got_to);
      end
      if (got_n == 64) begin
         checks++;
         if (got_d[0] !== 32'h61626380 || got_d[15] !== 32'h00000018 ||
             got_d[16] !== 32'h61626380 || got_d[17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL abc_known_words: got W0=%h W15=%h W16=%h W17=%h, need 61626380 00000018 61626380 000f0000",
                     got_d[0], got_d[15], got_d[16], got_d[17]);
         end
      end
      for (int k = 0; k < got_n; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== 6'(k) || got_l[k] !== (k == 63)) begin
            errors++;
            $display("FAIL abc_word: k=%0d got data=%h idx=%0d last=%b, need %h %0d %b",
                     k, got_d[k], got_i[k], got_l[k], exp_w[k], k, (k == 63));
         end
      end
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL abc_return_idle: got rdy=%b vld=%b busy=%b, need 1 0 0", bus.blk_ready, bus.w_valid, bus.busy);
      end
   endtask

   task automatic test_stall();
      logic [511:0] b;
      bit to;
      b = '0;
      b[511:480] = 32'h61626380;
      b[31:0]    = 32'h00000018;
      build_model(b);
      offer(b, 1'b0, to);
      collect(1'b1, -1);
      checks++;
      if (to || got_to || got_n != 64 || got_cycles <= 64) begin
         errors++;
         $display("FAIL stall_count: got words=%0d cycles=%0d to=%0d/%0d, need 64 words and >64 cycles",
                  got_n, got_cycles, to, got_to);
      end
      checks++;
      if (got_unstable != 0) begin
         errors++;
         $display("FAIL stall_stability: got %0d changes while stalled, need 0", got_unstable);
      end
      for (int k = 0; k < got_n; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== 6'(k) || got_l[k] !== (k == 63)) begin
            errors++;
            $display("FAIL stall_word: k=%0d got data=%h idx=%0d last=%b, need %h %0d %b",
                     k, got_d[k], got_i[k], got_l[k], exp_w[k], k, (k == 63));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] b1, b2;
      bit to;
      b1 = rand_block();
      b2 = rand_block();
      build_model(b1);
      offer(b1, 1'b1, to);
      bus.blk_data = b2;   // changes during RUN must not disturb block 1
      collect(1'b0, -1);
      checks++;
      if (to || got_to || got_n != 64) begin
         errors++;
         $display("FAIL b2b_first_count: got words=%0d to=%0d/%0d, need 64", got_n, to, got_to);
      end
      for (int k = 0; k < got_n; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== 6'(k)) begin
            errors++;
            $display("FAIL b2b_first_word: k=%0d got %h idx=%0d, need %h %0d", k, got_d[k], got_i[k], exp_w[k], k);
         end
      end
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap_cycle: got rdy=%b vld=%b, need 1 0", bus.blk_ready, bus.w_valid);
      end
      build_model(b2);
      @(posedge clk); #1;
      bus.blk_valid = 1'b0;
      bus.blk_data  = rand_block();
      checks++;
      if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'd0 || bus.w_data !== exp_w[0]) begin
         errors++;
         $display("FAIL b2b_second_accept: got vld=%b idx=%0d data=%h, need 1 0 %h",
                  bus.w_valid, bus.w_idx, bus.w_data, exp_w[0]);
      end
      collect(1'b0, -1);
      checks++;
      if (got_to || got_n != 64) begin
         errors++;
         $display("FAIL b2b_second_count: got words=%0d to=%0d, need 64", got_n, got_to);
      end
      for (int k = 0; k < got_n; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== 6'(k)) begin
            errors++;
            $display("FAIL b2b_second_word: k=%0d got %h idx=%0d, need %h %0d", k, got_d[k], got_i[k], exp_w[k], k);
         end
      end
   endtask

   task automatic test_all_ones();
      logic [511:0] b;
      bit to;
      b = '1;
      build_model(b);
      offer(b, 1'b0, to);
      collect(1'b1, -1);
      checks++;
      if (to || got_to || got_n != 64) begin
         errors++;
         $display("FAIL ones_count: got words=%0d to=%0d/%0d, need 64", got_n, to, got_to);
      end
      if (got_n == 64) begin
         checks++;
         if (got_d[16] !== 32'h203FFFFC) begin
            errors++;
            $display("FAIL ones_w16: got %h, need 203ffffc", got_d[16]);
         end
      end
      for (int k = 0; k < got_n; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k]) begin
            errors++;
            $display("FAIL ones_word: k=%0d got %h, need %h", k, got_d[k], exp_w[k]);
         end
      end
   endtask

   task automatic test_reset_mid_block();
      logic [511:0] b;
      bit to;
      b = rand_block();
      build_model(b);
      offer(b, 1'b0, to);
      collect(1'b0, 30);
      checks++;
      if (to || got_n != 30 || bus.w_idx !== 6'd30) begin
         errors++;
         $display("FAIL midrst_reach30: got words=%0d idx=%0d to=%0d, need 30 30", got_n, bus.w_idx, to);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.w_idx !== 6'd0) begin
         errors++;
         $display("FAIL midrst_async: got vld=%b rdy=%b busy=%b idx=%0d, need 0 1 0 0",
                  bus.w_valid, bus.blk_ready, bus.busy, bus.w_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      b = rand_block();
      build_model(b);
      offer(b, 1'b0, to);
      collect(1'b0, -1);
      checks++;
      if (to || got_to || got_n != 64) begin
         errors++;
         $display("FAIL midrst_count: got words=%0d to=%0d/%0d, need 64", got_n, to, got_to);
      end
      for (int k = 0; k < got_n; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== 6'(k)) begin
            errors++;
            $display("FAIL midrst_word: k=%0d got %h idx=%0d, need %h %0d", k, got_d[k], got_i[k], exp_w[k], k);
         end
      end
   endtask

   task automatic test_idle();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.blk_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.w_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: cycle=%0d got vld=%b busy=%b, need 0 0", c, bus.w_valid, bus.busy);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.w_ready   = 1'b0;
      #3;
      test_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_abc();
      test_stall();
      test_back_to_back();
      test_all_ones();
      test_reset_mid_block();
      test_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sha256_msg_schedule
